oam_dma: RTL

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/q2a03_pkg.sv | 16 +
 rtl/oam_dma.sv | 98 +++++++++
 2 files changed

// File: rtl/q2a03_pkg.sv
// Shared definitions for the 2A03-style sprite DMA engine.
package q2a03_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      HALT  = 3'd1,
      ALIGN = 3'd2,
      READ  = 3'd3,
      WRITE = 3'd4,
      DONE  = 3'd5
   } oam_state_t;

   localparam logic [15:0] OAM_DEST_ADDR  = 16'h2004;
   localparam int          OAM_XFER_BYTES = 256;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: copies one page of memory to a fixed write port, one
// read/write pair per byte, with an extra alignment cycle on odd starts.
module oam_dma
   import q2a03_pkg::*;
#(
   parameter int                     P_data_bits = 8,
   parameter int                     P_addr_bits = 16,
   parameter logic [P_addr_bits-1:0] P_dest_addr = P_addr_bits'(OAM_DEST_ADDR),
   parameter int                     P_length    = OAM_XFER_BYTES
) (
   input  logic                   I_clock,
   input  logic                   I_reset,
   input  logic                   I_start,
   input  logic [7:0]             I_page,
   input  logic                   I_odd,
   input  logic                   I_ready,
   input  logic [P_data_bits-1:0] I_data,
   output logic [P_addr_bits-1:0] O_addr,
   output logic                   O_wren,
   output logic [P_data_bits-1:0] O_data,
   output logic                   O_busy,
   output logic                   O_done
);

   localparam logic [7:0] LAST_COUNT = 8'(P_length - 1);

   oam_state_t             state, state_nxt;
   logic [7:0]             count;
   logic [7:0]             page;
   logic                   odd;
   logic                   first;
   logic [P_data_bits-1:0] hold;

   always_ff @(posedge I_clock or posedge I_reset) begin
      if (I_reset) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (I_start) state_nxt = HALT;
         HALT:  if (I_ready) state_nxt = odd ? ALIGN : READ;
         ALIGN: if (I_ready) state_nxt = READ;
         READ:  if (I_ready) state_nxt = WRITE;
         WRITE: if (I_ready) state_nxt = (count == LAST_COUNT) ? DONE : READ;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // first marks the cycle where read data is live on I_data; it is
   // captured then so a stalled write can finish from hold later.
   always_ff @(posedge I_clock or posedge I_reset) begin
      if (I_reset) begin
         count <= '0;
         page  <= '0;
         odd   <= 1'b0;
         first <= 1'b0;
         hold  <= '0;
      end else begin
         first <= (state == READ) && I_ready;
         case (state)
            IDLE: begin
               if (I_start) begin
                  page  <= I_page;
                  odd   <= I_odd;
                  count <= '0;
               end
            end
            WRITE: begin
               if (first)   hold  <= I_data;
               if (I_ready) count <= count + 8'd1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      O_addr = '0;
      O_wren = 1'b0;
      O_data = '0;
      case (state)
         READ:  O_addr = P_addr_bits'({page, count});
         WRITE: begin
            O_addr = P_dest_addr;
            O_wren = I_ready;
            O_data = first ? I_data : hold;
         end
         default: ;
      endcase
   end

   assign O_busy = (state != IDLE);
   assign O_done = (state == DONE);

endmodule
